// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter that shares one WIDTH-bit register among NREQ requesters,
// with an optional lock that lets the winner reload consecutively up to MAX_LOCK cycles.
module dff_share_arbiter #(
    parameter int WIDTH    = 8,
    parameter int NREQ     = 4,
    parameter int MAX_LOCK = 16
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NREQ-1:0]            REQ,
    input  logic [NREQ-1:0]            LOCK,
    input  logic [NREQ*WIDTH-1:0]      D_IN,
    output logic [NREQ-1:0]            GNT,
    output logic [WIDTH-1:0]           Q,
    output logic                       Q_VALID,
    output logic [$clog2(NREQ)-1:0]    OWNER,
    output logic                       LOCKED
);

    localparam int IW = $clog2(NREQ);
    localparam int HW = $clog2(MAX_LOCK + 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t            state_p1, state_d;
    logic [NREQ-1:0]   gnt_p1, gnt_d;
    logic [WIDTH-1:0]  q_p1, q_d;
    logic              vld_p1, vld_d;
    logic [IW-1:0]     owner_p1, owner_d;
    logic [IW-1:0]     ptr_p1, ptr_d;
    logic [HW-1:0]     hc_p1, hc_d;

    logic              hold_p0;
    logic [IW-1:0]     arb_ptr_p0;
    logic [IW-1:0]     win_p0;
    logic              any_p0;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        if (i == IW'(NREQ - 1)) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // Stage p0: decide hold vs. release, then search circularly from the effective pointer.
    always_comb begin
        hold_p0    = (state_p1 == S_LOCKED) && REQ[owner_p1] && LOCK[owner_p1]
                     && (hc_p1 < HW'(MAX_LOCK));
        // On release the old owner drops to lowest priority in the same cycle.
        arb_ptr_p0 = (state_p1 == S_LOCKED) ? next_idx(owner_p1) : ptr_p1;
    end

    always_comb begin
        int idx;
        idx    = 0;
        win_p0 = '0;
        any_p0 = 1'b0;
        // Descending scan so the smallest circular offset is the last one written.
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(arb_ptr_p0) + k) % NREQ;
            if (REQ[idx]) begin
                win_p0 = IW'(idx);
                any_p0 = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_p1;
        gnt_d   = gnt_p1;
        q_d     = q_p1;
        vld_d   = 1'b0;
        owner_d = owner_p1;
        ptr_d   = ptr_p1;
        hc_d    = hc_p1;
        if (hold_p0) begin
            q_d   = D_IN[owner_p1*WIDTH +: WIDTH];
            vld_d = 1'b1;
            hc_d  = hc_p1 + 1'b1;
        end else if (any_p0) begin
            gnt_d         = '0;
            gnt_d[win_p0] = 1'b1;
            q_d           = D_IN[win_p0*WIDTH +: WIDTH];
            vld_d         = 1'b1;
            owner_d       = win_p0;
            if (LOCK[win_p0]) begin
                state_d = S_LOCKED;
                hc_d    = HW'(1);
                ptr_d   = arb_ptr_p0;
            end else begin
                state_d = S_IDLE;
                hc_d    = '0;
                ptr_d   = next_idx(win_p0);
            end
        end else begin
            state_d = S_IDLE;
            gnt_d   = '0;
            hc_d    = '0;
            ptr_d   = arb_ptr_p0;
        end
    end

    // Stage p1: registered arbiter state and shared register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_p1 <= S_IDLE;
            gnt_p1   <= '0;
            q_p1     <= '0;
            vld_p1   <= 1'b0;
            owner_p1 <= '0;
            ptr_p1   <= '0;
            hc_p1    <= '0;
        end else begin
            state_p1 <= state_d;
            gnt_p1   <= gnt_d;
            q_p1     <= q_d;
            vld_p1   <= vld_d;
            owner_p1 <= owner_d;
            ptr_p1   <= ptr_d;
            hc_p1    <= hc_d;
        end
    end

    always_comb begin
        GNT     = gnt_p1;
        Q       = q_p1;
        Q_VALID = vld_p1;
        OWNER   = owner_p1;
        LOCKED  = (state_p1 == S_LOCKED);
    end

    a_gnt_onehot0 : assert property (@(posedge CLK) disable iff (RST) $onehot0(GNT));
    a_gnt_owner   : assert property (@(posedge CLK) disable iff (RST) (GNT != '0) |-> GNT[OWNER]);
    a_vld_gnt     : assert property (@(posedge CLK) disable iff (RST) Q_VALID |-> (GNT != '0));

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Directed scoreboard bench for dff_share_arbiter (NREQ=4, WIDTH=8, MAX_LOCK=4).
module tb_dff_share_arbiter;

    logic        CLK;
    logic        RST;
    logic [3:0]  REQ;
    logic [3:0]  LOCK;
    logic [31:0] D_IN;
    logic [3:0]  GNT;
    logic [7:0]  Q;
    logic        Q_VALID;
    logic [1:0]  OWNER;
    logic        LOCKED;

    dff_share_arbiter #(.WIDTH(8), .NREQ(4), .MAX_LOCK(4)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .LOCK(LOCK), .D_IN(D_IN),
        .GNT(GNT), .Q(Q), .Q_VALID(Q_VALID), .OWNER(OWNER), .LOCKED(LOCKED)
    );

    typedef struct {
        logic [3:0] gnt;
        logic [7:0] q;
        logic       qv;
        logic [1:0] own;
        logic       lk;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] pk(input logic [7:0] b0, b1, b2, b3);
        return {b3, b2, b1, b0};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: one scoreboard entry per clock edge, sampled 1 time unit after it.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({e.tag, ".gnt"},    {4'b0, GNT},     {4'b0, e.gnt});
            chk({e.tag, ".q"},      Q,               e.q);
            chk({e.tag, ".qvalid"}, {7'b0, Q_VALID}, {7'b0, e.qv});
            chk({e.tag, ".owner"},  {6'b0, OWNER},   {6'b0, e.own});
            chk({e.tag, ".locked"}, {7'b0, LOCKED},  {7'b0, e.lk});
        end
    end

    task automatic step(input string tag, input logic rst, input logic [3:0] req,
                        input logic [3:0] lock, input logic [31:0] din,
                        input logic [3:0] egnt, input logic [7:0] eq, input logic eqv,
                        input logic [1:0] eown, input logic elk);
        exp_t e;
        @(negedge CLK);
        RST  = rst;
        REQ  = req;
        LOCK = lock;
        D_IN = din;
        e.gnt = egnt; e.q = eq; e.qv = eqv; e.own = eown; e.lk = elk; e.tag = tag;
        sb.push_back(e);
        @(posedge CLK);
    endtask

    initial begin
        logic [3:0] rr_gnt [4];
        rr_gnt[0] = 4'b0001; rr_gnt[1] = 4'b0010; rr_gnt[2] = 4'b0100; rr_gnt[3] = 4'b1000;
        RST = 1'b1; REQ = '0; LOCK = '0; D_IN = '0;

        for (int i = 0; i < 3; i++)
            step("reset", 1'b1, 4'($urandom), 4'($urandom), 32'($urandom),
                 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
        step("first_grant", 1'b0, 4'b0001, 4'b0000, pk(8'h5A, 8'h00, 8'h00, 8'h00),
             4'b0001, 8'h5A, 1'b1, 2'd0, 1'b0);

        step("reset2", 1'b1, 4'b0000, 4'b0000, '0, 4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
        for (int i = 0; i < 8; i++)
            step("round_robin", 1'b0, 4'b1111, 4'b0000, pk(8'h10, 8'h11, 8'h12, 8'h13),
                 rr_gnt[i % 4], 8'(8'h10 + (i % 4)), 1'b1, 2'(i % 4), 1'b0);

        // Move the pointer to 2 before the lock scenario.
        step("ptr_to_2", 1'b0, 4'b0010, 4'b0000, pk(8'h00, 8'h11, 8'h00, 8'h00),
             4'b0010, 8'h11, 1'b1, 2'd1, 1'b0);
        step("lock_c1", 1'b0, 4'b0101, 4'b0100, pk(8'h77, 8'h00, 8'hC3, 8'h00),
             4'b0100, 8'hC3, 1'b1, 2'd2, 1'b1);
        step("lock_c2", 1'b0, 4'b0101, 4'b0100, pk(8'h77, 8'h00, 8'h3C, 8'h00),
             4'b0100, 8'h3C, 1'b1, 2'd2, 1'b1);
        step("lock_c3", 1'b0, 4'b0101, 4'b0100, pk(8'h77, 8'h00, 8'hC3, 8'h00),
             4'b0100, 8'hC3, 1'b1, 2'd2, 1'b1);
        step("handover", 1'b0, 4'b0101, 4'b0000, pk(8'h77, 8'h00, 8'h99, 8'h00),
             4'b0001, 8'h77, 1'b1, 2'd0, 1'b0);

        // Pointer goes 1 -> 2 so requester 0 wins the timeout scenario first.
        step("ptr_to_2b", 1'b0, 4'b0010, 4'b0000, pk(8'h00, 8'hB1, 8'h00, 8'h00),
             4'b0010, 8'hB1, 1'b1, 2'd1, 1'b0);
        for (int k = 0; k < 4; k++)
            step("timeout_hold", 1'b0, 4'b0011, 4'b0001,
                 pk(8'(8'hA0 + k), 8'hB1, 8'h00, 8'h00),
                 4'b0001, 8'(8'hA0 + k), 1'b1, 2'd0, 1'b1);
        step("timeout_release", 1'b0, 4'b0011, 4'b0001, pk(8'hA4, 8'hB1, 8'h00, 8'h00),
             4'b0010, 8'hB1, 1'b1, 2'd1, 1'b0);
        step("timeout_regrant", 1'b0, 4'b0011, 4'b0001, pk(8'hA5, 8'hB1, 8'h00, 8'h00),
             4'b0001, 8'hA5, 1'b1, 2'd0, 1'b1);

        for (int i = 0; i < 5; i++)
            step("idle_hold", 1'b0, 4'b0000, 4'b0000, 32'hFFFF_FFFF,
                 4'b0000, 8'hA5, 1'b0, 2'd0, 1'b0);

        step("lock3_c1", 1'b0, 4'b1000, 4'b1000, pk(8'h00, 8'h00, 8'h00, 8'hD3),
             4'b1000, 8'hD3, 1'b1, 2'd3, 1'b1);
        step("lock3_c2", 1'b0, 4'b1000, 4'b1000, pk(8'h00, 8'h00, 8'h00, 8'hD4),
             4'b1000, 8'hD4, 1'b1, 2'd3, 1'b1);
        step("reset_midlock", 1'b1, 4'b1000, 4'b1000, pk(8'h00, 8'h00, 8'h00, 8'hD5),
             4'b0000, 8'h00, 1'b0, 2'd0, 1'b0);
        step("post_reset_ptr", 1'b0, 4'b1111, 4'b0000, pk(8'h20, 8'h21, 8'h22, 8'h23),
             4'b0001, 8'h20, 1'b1, 2'd0, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge CLK);
        @(negedge CLK);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
